univ_ff_bank: RTL and testbench

Parametrised bank of WIDTH flip-flops with a run-time selectable storage mode: SR, JK, D or T. All bits share one clock, one enable and one mode. Adds a configurable SR-conflict policy, a sticky conflict flag and a saturating output-change counter. Serves as the general storage primitive for control and status registers, replacing single-bit SR flip-flop instances.

---
 rtl/ff_pkg.sv | 10 +
 rtl/ff_next_state.sv | 25 ++
 rtl/univ_ff_bank.sv | 52 +++++
 tb/tb_univ_ff_bank.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// ff_pkg: mode encodings and SR-conflict policies for univ_ff_bank
package ff_pkg;
  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;
  localparam int POL_HOLD = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;
endpackage

// File: rtl/ff_next_state.sv
// ff_next_state: one-bit next-state and SR-conflict decode for univ_ff_bank
module ff_next_state
  import ff_pkg::*;
#(
  parameter int POL = POL_HOLD
) (
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       q,
  output logic       nq,
  output logic       cf
);
  logic keep;
  logic pol_q;
  always_comb begin
    keep  = a | (q & ~b);
    pol_q = POL == POL_SET ? 1'b1 : POL == POL_RST ? 1'b0 : q;
    cf    = mode == MODE_SR && a && b;
    nq    = mode == MODE_D  ? a :
            mode == MODE_T  ? q ^ a :
            mode == MODE_JK ? (a && b ? ~q : keep) :
                              (a && b ? pol_q : keep);
  end
endmodule

// File: rtl/univ_ff_bank.sv
// univ_ff_bank: WIDTH-bit SR/JK/D/T register bank with conflict flags and change counter
module univ_ff_bank
  import ff_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SR_CONFLICT = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             conflict,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] chg_cnt
);
  logic [WIDTH-1:0] nq;
  logic [WIDTH-1:0] cf;
  logic             hit;
  logic             inc;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ff_next_state #(.POL(SR_CONFLICT)) u_ns (
      .mode (mode),
      .a    (a[i]),
      .b    (b[i]),
      .q    (q[i]),
      .nq   (nq[i]),
      .cf   (cf[i])
    );
  end
  assign qbar = ~q;
  assign hit  = en & |cf;
  assign inc  = en && nq != q && chg_cnt != {CNT_W{1'b1}};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q               <= '0;
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      chg_cnt         <= '0;
    end else begin
      if (en) q <= nq;
      conflict        <= hit;
      conflict_sticky <= clr ? 1'b0 : hit | conflict_sticky;
      chg_cnt         <= clr ? '0 : inc ? chg_cnt + 1'b1 : chg_cnt;
    end
  end
endmodule

// File: tb/tb_univ_ff_bank.sv
// tb_univ_ff_bank: directed self-checking bench, one DUT per SR conflict policy
module tb_univ_ff_bank;
  logic       clk = 0;
  logic       rst = 0;
  logic       en = 0;
  logic [1:0] mode = 0;
  logic [3:0] a = 0;
  logic [3:0] b = 0;
  logic       clr = 0;
  logic [3:0] q0, q1, q2, qb0, qb1, qb2;
  logic       c0, c1, c2, s0, s1, s2;
  logic [3:0] n0, n1, n2;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  univ_ff_bank #(.WIDTH(4), .SR_CONFLICT(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr(clr),
    .q(q0), .qbar(qb0), .conflict(c0), .conflict_sticky(s0), .chg_cnt(n0));
  univ_ff_bank #(.WIDTH(4), .SR_CONFLICT(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr(clr),
    .q(q1), .qbar(qb1), .conflict(c1), .conflict_sticky(s1), .chg_cnt(n1));
  univ_ff_bank #(.WIDTH(4), .SR_CONFLICT(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr(clr),
    .q(q2), .qbar(qb2), .conflict(c2), .conflict_sticky(s2), .chg_cnt(n2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks += 5;
    if (q0 !== 4'b0000) begin errors++; $display("FAIL reset_q got=%b exp=0000", q0); end
    if (qb0 !== 4'b1111) begin errors++; $display("FAIL reset_qbar got=%b exp=1111", qb0); end
    if (c0 !== 1'b0) begin errors++; $display("FAIL reset_conflict got=%b exp=0", c0); end
    if (s0 !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=0", s0); end
    if (n0 !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", n0); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_sr();
    en = 1; mode = 2'b00; a = 4'b0011; b = 4'b0000;
    tick();
    checks += 2;
    if (q0 !== 4'b0011) begin errors++; $display("FAIL sr_set got=%b exp=0011", q0); end
    if (n0 !== 4'd1) begin errors++; $display("FAIL sr_set_cnt got=%0d exp=1", n0); end
    a = 4'b0000; b = 4'b0001;
    tick();
    checks += 3;
    if (q0 !== 4'b0010) begin errors++; $display("FAIL sr_reset got=%b exp=0010", q0); end
    if (n0 !== 4'd2) begin errors++; $display("FAIL sr_reset_cnt got=%0d exp=2", n0); end
    if (c0 !== 1'b0) begin errors++; $display("FAIL sr_noconflict got=%b exp=0", c0); end
  endtask

  task automatic test_conflict();
    a = 4'b0110; b = 4'b0100;
    tick();
    checks += 9;
    if (q0 !== 4'b0010) begin errors++; $display("FAIL pol_hold_q got=%b exp=0010", q0); end
    if (q1 !== 4'b0110) begin errors++; $display("FAIL pol_set_q got=%b exp=0110", q1); end
    if (q2 !== 4'b0010) begin errors++; $display("FAIL pol_rst_q got=%b exp=0010", q2); end
    if ({c0, c1, c2} !== 3'b111) begin errors++; $display("FAIL conflict_pulse got=%b exp=111", {c0, c1, c2}); end
    if ({s0, s1, s2} !== 3'b111) begin errors++; $display("FAIL conflict_sticky got=%b exp=111", {s0, s1, s2}); end
    if (n0 !== 4'd2) begin errors++; $display("FAIL conflict_cnt_hold got=%0d exp=2", n0); end
    if (n1 !== 4'd3) begin errors++; $display("FAIL conflict_cnt_set got=%0d exp=3", n1); end
    if (qb1 !== 4'b1001) begin errors++; $display("FAIL pol_set_qbar got=%b exp=1001", qb1); end
    if (n2 !== 4'd2) begin errors++; $display("FAIL conflict_cnt_rst got=%0d exp=2", n2); end
    a = 4'b0000; b = 4'b0000;
    tick();
    checks += 2;
    if (c0 !== 1'b0) begin errors++; $display("FAIL conflict_one_cycle got=%b exp=0", c0); end
    if (s0 !== 1'b1) begin errors++; $display("FAIL sticky_holds got=%b exp=1", s0); end
  endtask

  task automatic test_async_reset();
    mode = 2'b10; a = 4'b1010;
    tick();
    checks += 1;
    if (q0 !== 4'b1010) begin errors++; $display("FAIL preload_q got=%b exp=1010", q0); end
    #2 rst = 0;
    #1;
    checks += 4;
    if (q0 !== 4'b0000) begin errors++; $display("FAIL async_q got=%b exp=0000", q0); end
    if (qb0 !== 4'b1111) begin errors++; $display("FAIL async_qbar got=%b exp=1111", qb0); end
    if (n0 !== 4'd0) begin errors++; $display("FAIL async_cnt got=%0d exp=0", n0); end
    if (s0 !== 1'b0) begin errors++; $display("FAIL async_sticky got=%b exp=0", s0); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_jk();
    mode = 2'b10; a = 4'b0010;
    tick();
    mode = 2'b01; a = 4'b1111; b = 4'b1111;
    tick();
    checks += 3;
    if (q0 !== 4'b1101) begin errors++; $display("FAIL jk_toggle1 got=%b exp=1101", q0); end
    if (n0 !== 4'd2) begin errors++; $display("FAIL jk_cnt1 got=%0d exp=2", n0); end
    if (c0 !== 1'b0) begin errors++; $display("FAIL jk_noconflict got=%b exp=0", c0); end
    tick();
    checks += 2;
    if (q0 !== 4'b0010) begin errors++; $display("FAIL jk_toggle2 got=%b exp=0010", q0); end
    if (n0 !== 4'd3) begin errors++; $display("FAIL jk_cnt2 got=%0d exp=3", n0); end
    mode = 2'b01; a = 4'b0101; b = 4'b1010;
    tick();
    checks += 1;
    if (q0 !== 4'b0101) begin errors++; $display("FAIL jk_setreset got=%b exp=0101", q0); end
  endtask

  task automatic test_d_t();
    mode = 2'b10; a = 4'b1010; en = 0;
    tick();
    checks += 2;
    if (q0 !== 4'b0101) begin errors++; $display("FAIL en_hold_q got=%b exp=0101", q0); end
    if (n0 !== 4'd4) begin errors++; $display("FAIL en_hold_cnt got=%0d exp=4", n0); end
    en = 1;
    tick();
    checks += 2;
    if (q0 !== 4'b1010) begin errors++; $display("FAIL d_load got=%b exp=1010", q0); end
    if (n0 !== 4'd5) begin errors++; $display("FAIL d_cnt got=%0d exp=5", n0); end
    mode = 2'b11; a = 4'b0011;
    tick();
    checks += 2;
    if (q0 !== 4'b1001) begin errors++; $display("FAIL t_toggle got=%b exp=1001", q0); end
    if (n0 !== 4'd6) begin errors++; $display("FAIL t_cnt got=%0d exp=6", n0); end
  endtask

  task automatic test_sat_clr();
    mode = 2'b11; a = 4'b0001;
    for (int i = 0; i < 20; i++) tick();
    checks += 2;
    if (n0 !== 4'd15) begin errors++; $display("FAIL sat_cnt got=%0d exp=15", n0); end
    if (q0 !== 4'b1001) begin errors++; $display("FAIL sat_q got=%b exp=1001", q0); end
    mode = 2'b00; a = 4'b0001; b = 4'b0001;
    tick();
    checks += 2;
    if (s0 !== 1'b1) begin errors++; $display("FAIL pre_clr_sticky got=%b exp=1", s0); end
    if (n0 !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", n0); end
    clr = 1;
    tick();
    checks += 3;
    if (s0 !== 1'b0) begin errors++; $display("FAIL clr_vs_conflict_sticky got=%b exp=0", s0); end
    if (c0 !== 1'b1) begin errors++; $display("FAIL clr_vs_conflict_pulse got=%b exp=1", c0); end
    if (n0 !== 4'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", n0); end
    mode = 2'b11; a = 4'b0001;
    tick();
    checks += 3;
    if (q0 !== 4'b1000) begin errors++; $display("FAIL clr_q_toggle got=%b exp=1000", q0); end
    if (n0 !== 4'd0) begin errors++; $display("FAIL clr_vs_inc got=%0d exp=0", n0); end
    if (s0 !== 1'b0) begin errors++; $display("FAIL clr_sticky got=%b exp=0", s0); end
    clr = 0;
    tick();
    checks += 2;
    if (q0 !== 4'b1001) begin errors++; $display("FAIL post_clr_q got=%b exp=1001", q0); end
    if (n0 !== 4'd1) begin errors++; $display("FAIL post_clr_cnt got=%0d exp=1", n0); end
  endtask

  initial begin
    test_reset();
    test_sr();
    test_conflict();
    test_async_reset();
    test_jk();
    test_d_t();
    test_sat_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
